// File: rtl/iir_biquad_2ch.sv
// iir_biquad_2ch: dual-channel Direct-Form-I biquad sharing one multiplier across both channels
// Ports:
//   clk, rst_i (async, active high), en_i, data_update_i, data0_i/data1_i (offset binary in)
//   data_valid_o (one-cycle strobe), data0_o/data1_o (offset binary out), busy_o, overrun_o (sticky)
//   bypass_i exists only when IIR_BYPASS_EN is defined: outputs follow inputs, histories take y = x
module iir_biquad_2ch #(
    parameter logic signed [15:0] B0 = 16'sd16384,
    parameter logic signed [15:0] B1 = 16'sd0,
    parameter logic signed [15:0] B2 = 16'sd0,
    parameter logic signed [15:0] A1 = 16'sd0,
    parameter logic signed [15:0] A2 = 16'sd0
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        data_update_i,
    input  logic [11:0] data0_i,
    input  logic [11:0] data1_i,
`ifdef IIR_BYPASS_EN
    input  logic        bypass_i,
`endif
    output logic        data_valid_o,
    output logic [11:0] data0_o,
    output logic [11:0] data1_o,
    output logic        busy_o,
    output logic        overrun_o
);
    typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] k, tap;
    logic ch, start;
    logic signed [11:0] x [2], x1 [2], x2 [2], y1 [2], y2 [2], yv [2], opd;
    logic signed [15:0] coef;
    logic signed [31:0] acc [2], prod;
`ifdef IIR_BYPASS_EN
    logic byp;
`endif

    function automatic logic signed [11:0] sat(input logic signed [31:0] a);
        logic signed [31:0] r;
        r = (a + 32'sd8192) >>> 14;
        return (r > 32'sd2047) ? 12'sh7ff : (r < -32'sd2048) ? 12'sh800 : r[11:0];
    endfunction

    assign start = data_update_i && en_i && state == IDLE;
    assign busy_o = state != IDLE;
    assign data_valid_o = state == DONE;
    // taps 0..4 of channel 0 occupy k = 0..4, channel 1 occupies k = 5..9
    assign ch = k >= 4'd5;
    assign tap = ch ? k - 4'd5 : k;

    always_comb begin
        opd = tap == 4'd0 ? x[ch] : tap == 4'd1 ? x1[ch] : tap == 4'd2 ? x2[ch] : tap == 4'd3 ? y1[ch] : y2[ch];
        coef = tap == 4'd0 ? B0 : tap == 4'd1 ? B1 : tap == 4'd2 ? B2 : tap == 4'd3 ? A1 : A2;
        prod = opd * coef;
        for (int c = 0; c < 2; c++)
`ifdef IIR_BYPASS_EN
            yv[c] = byp ? x[c] : sat(acc[c]);
`else
            yv[c] = sat(acc[c]);
`endif
        state_nx = state == IDLE ? (start ? MAC : IDLE) :
                   state == MAC  ? (k == 4'd9 ? SAT : MAC) :
                   state == SAT  ? DONE : IDLE;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < 2; c++) begin
                x[c] <= '0;
                x1[c] <= '0;
                x2[c] <= '0;
                y1[c] <= '0;
                y2[c] <= '0;
                acc[c] <= '0;
            end
            k <= '0;
            data0_o <= 12'h800;
            data1_o <= 12'h800;
            overrun_o <= 1'b0;
`ifdef IIR_BYPASS_EN
            byp <= 1'b0;
`endif
        end else begin
            if (data_update_i && en_i && busy_o)
                overrun_o <= 1'b1;
            if (start) begin
                x[0] <= $signed({~data0_i[11], data0_i[10:0]});
                x[1] <= $signed({~data1_i[11], data1_i[10:0]});
                acc[0] <= '0;
                acc[1] <= '0;
                k <= '0;
`ifdef IIR_BYPASS_EN
                byp <= bypass_i;
`endif
            end
            if (state == MAC) begin
                // feedback taps (a1, a2) are subtracted
                acc[ch] <= tap >= 4'd3 ? acc[ch] - prod : acc[ch] + prod;
                k <= k + 4'd1;
            end
            if (state == SAT) begin
                for (int c = 0; c < 2; c++) begin
                    x2[c] <= x1[c];
                    x1[c] <= x[c];
                    y2[c] <= y1[c];
                    y1[c] <= yv[c];
                end
                data0_o <= {~yv[0][11], yv[0][10:0]};
                data1_o <= {~yv[1][11], yv[1][10:0]};
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_2ch.sv
// tb_iir_biquad_2ch: randomized self-checking bench for iir_biquad_2ch against an arithmetic reference model
module tb_iir_biquad_2ch;
    logic clk = 1'b0, rst_i = 1'b1, en_i = 1'b1, data_update_i = 1'b0;
    logic [11:0] data0_i = '0, data1_i = '0;
    logic [11:0] dout [3][2];
    logic vld [3], bsy [3], ovr [3];
    int total = 0, bad = 0;
    int cf [3][5] = '{'{16384, 0, 0, 0, 0}, '{8192, 0, 0, -8192, 0}, '{24576, 16384, -8192, -8192, 4096}};
    int hx1 [3][2], hx2 [3][2], hy1 [3][2], hy2 [3][2];
    logic [11:0] exp_o [3][2], prev [3][2];
    logic [15:0] vtr [3], btr [3];
    logic held [3];

    always #5 clk = ~clk;

    iir_biquad_2ch u_id (
        .clk(clk), .rst_i(rst_i), .en_i(en_i), .data_update_i(data_update_i),
        .data0_i(data0_i), .data1_i(data1_i), .data_valid_o(vld[0]),
        .data0_o(dout[0][0]), .data1_o(dout[0][1]), .busy_o(bsy[0]), .overrun_o(ovr[0]));
    iir_biquad_2ch #(.B0(16'sd8192), .A1(-16'sd8192)) u_fb (
        .clk(clk), .rst_i(rst_i), .en_i(en_i), .data_update_i(data_update_i),
        .data0_i(data0_i), .data1_i(data1_i), .data_valid_o(vld[1]),
        .data0_o(dout[1][0]), .data1_o(dout[1][1]), .busy_o(bsy[1]), .overrun_o(ovr[1]));
    iir_biquad_2ch #(.B0(16'sd24576), .B1(16'sd16384), .B2(-16'sd8192), .A1(-16'sd8192), .A2(16'sd4096)) u_gen (
        .clk(clk), .rst_i(rst_i), .en_i(en_i), .data_update_i(data_update_i),
        .data0_i(data0_i), .data1_i(data1_i), .data_valid_o(vld[2]),
        .data0_o(dout[2][0]), .data1_o(dout[2][1]), .busy_o(bsy[2]), .overrun_o(ovr[2]));

    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++) begin
                hx1[i][c] = 0; hx2[i][c] = 0; hy1[i][c] = 0; hy2[i][c] = 0;
                exp_o[i][c] = 12'h800;
            end
    endtask

    task automatic model_step(input logic [11:0] d0, input logic [11:0] d1);
        logic [11:0] d [2];
        logic signed [11:0] xs;
        int xv, acc, y;
        d[0] = d0; d[1] = d1;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++) begin
                xs = d[c] ^ 12'h800;
                xv = xs;
                acc = cf[i][0] * xv + cf[i][1] * hx1[i][c] + cf[i][2] * hx2[i][c]
                    - cf[i][3] * hy1[i][c] - cf[i][4] * hy2[i][c];
                y = (acc + 8192) >>> 14;
                y = y > 2047 ? 2047 : y < -2048 ? -2048 : y;
                hx2[i][c] = hx1[i][c]; hx1[i][c] = xv;
                hy2[i][c] = hy1[i][c]; hy1[i][c] = y;
                exp_o[i][c] = 12'(y) ^ 12'h800;
            end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        model_clear();
    endtask

    // drives one strobe and records valid/busy traces per cycle after the sampling edge
    task automatic run_frame(input logic [11:0] d0, input logic [11:0] d1, input logic en,
                             input int inj_at, input int endrop_at, input int ncyc);
        @(negedge clk);
        en_i = en; data0_i = d0; data1_i = d1; data_update_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev[i] = dout[i]; vtr[i] = '0; btr[i] = '0; held[i] = 1'b1;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vtr[i][c] = vld[i];
                btr[i][c] = bsy[i];
                if (c < 12 && (dout[i][0] !== prev[i][0] || dout[i][1] !== prev[i][1])) held[i] = 1'b0;
            end
            data_update_i = c == inj_at;
            if (c == inj_at) begin data0_i = $urandom; data1_i = $urandom; end
            if (c == endrop_at) en_i = 1'b0;
        end
        data_update_i = 1'b0;
        en_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++; if (dout[i][0] !== 12'h800 || dout[i][1] !== 12'h800) begin bad++;
                $display("FAIL reset_out inst%0d: got %h/%h want 800/800", i, dout[i][0], dout[i][1]); end
            total++; if ({vld[i], bsy[i], ovr[i]} !== 3'b000) begin bad++;
                $display("FAIL reset_flags inst%0d: got %b want 000", i, {vld[i], bsy[i], ovr[i]}); end
        end
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic test_identity();
        run_frame(12'hA5A, 12'h5A5, 1'b1, 0, 0, 12);
        model_step(12'hA5A, 12'h5A5);
        total++; if (dout[0][0] !== 12'hA5A || dout[0][1] !== 12'h5A5) begin bad++;
            $display("FAIL identity_out: got %h/%h want a5a/5a5", dout[0][0], dout[0][1]); end
        for (int i = 0; i < 3; i++) begin
            total++; if (vtr[i] !== 16'h1000) begin bad++;
                $display("FAIL identity_valid inst%0d: got %h want 1000", i, vtr[i]); end
            total++; if (btr[i] !== 16'h1ffe) begin bad++;
                $display("FAIL identity_busy inst%0d: got %h want 1ffe", i, btr[i]); end
            total++; if (held[i] !== 1'b1) begin bad++;
                $display("FAIL identity_hold inst%0d: got %b want 1", i, held[i]); end
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                    $display("FAIL identity_model inst%0d ch%0d: got %h want %h", i, c, dout[i][c], exp_o[i][c]); end
            end
        end
    endtask

    task automatic test_en_low();
        run_frame(12'h321, 12'h654, 1'b0, 0, 0, 12);
        for (int i = 0; i < 3; i++) begin
            total++; if (vtr[i] !== 16'h0 || btr[i] !== 16'h0 || ovr[i] !== 1'b0) begin bad++;
                $display("FAIL en_low inst%0d: got v=%h b=%h o=%b want 0/0/0", i, vtr[i], btr[i], ovr[i]); end
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                    $display("FAIL en_low_out inst%0d ch%0d: got %h want %h", i, c, dout[i][c], exp_o[i][c]); end
            end
        end
    endtask

    task automatic test_en_fall();
        run_frame(12'h9ab, 12'h234, 1'b1, 0, 3, 12);
        model_step(12'h9ab, 12'h234);
        for (int i = 0; i < 3; i++) begin
            total++; if (vtr[i] !== 16'h1000) begin bad++;
                $display("FAIL en_fall_valid inst%0d: got %h want 1000", i, vtr[i]); end
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                    $display("FAIL en_fall_out inst%0d ch%0d: got %h want %h", i, c, dout[i][c], exp_o[i][c]); end
            end
        end
    endtask

    task automatic test_feedback();
        logic [11:0] fb_exp [3] = '{12'hA00, 12'hB00, 12'hB80};
        pulse_reset();
        for (int n = 0; n < 12; n++) begin
            run_frame(12'hC00, 12'hC00, 1'b1, 0, 0, 12);
            model_step(12'hC00, 12'hC00);
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[1][c] !== exp_o[1][c]) begin bad++;
                    $display("FAIL feedback_model n%0d ch%0d: got %h want %h", n, c, dout[1][c], exp_o[1][c]); end
            end
            if (n < 3) begin
                total++; if (dout[1][0] !== fb_exp[n]) begin bad++;
                    $display("FAIL feedback_step n%0d: got %h want %h", n, dout[1][0], fb_exp[n]); end
            end
            if (n >= 10) begin
                total++; if (dout[1][0] !== 12'hC00) begin bad++;
                    $display("FAIL feedback_conv n%0d: got %h want c00", n, dout[1][0]); end
            end
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [11:0] seq [11] = '{12'hFFF, 12'h000, 12'h800, 12'hFFF, 12'hFFF, 12'hFFF,
                                  12'h000, 12'h000, 12'h000, 12'h7FF, 12'h801};
        logic [11:0] a, b;
        for (int n = 0; n < 40; n++) begin
            a = n < 11 ? seq[n] : 12'($urandom);
            b = n < 11 ? ~seq[n] : 12'($urandom);
            run_frame(a, b, 1'b1, 0, 0, 12);
            model_step(a, b);
            for (int i = 0; i < 3; i++) begin
                total++; if (vtr[i] !== 16'h1000 || btr[i] !== 16'h1ffe || held[i] !== 1'b1) begin bad++;
                    $display("FAIL random_timing n%0d inst%0d: got v=%h b=%h h=%b want 1000/1ffe/1", n, i, vtr[i], btr[i], held[i]); end
                for (int c = 0; c < 2; c++) begin
                    total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                        $display("FAIL random_out n%0d inst%0d ch%0d: got %h want %h", n, i, c, dout[i][c], exp_o[i][c]); end
                end
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a, b;
        for (int n = 0; n < 4; n++) begin
            a = $urandom; b = $urandom;
            run_frame(a, b, 1'b1, 0, 0, 12);
            model_step(a, b);
            for (int i = 0; i < 3; i++) begin
                total++; if (vtr[i] !== 16'h1000 || btr[i] !== 16'h1ffe || ovr[i] !== 1'b0) begin bad++;
                    $display("FAIL b2b_timing n%0d inst%0d: got v=%h b=%h o=%b want 1000/1ffe/0", n, i, vtr[i], btr[i], ovr[i]); end
                for (int c = 0; c < 2; c++) begin
                    total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                        $display("FAIL b2b_out n%0d inst%0d ch%0d: got %h want %h", n, i, c, dout[i][c], exp_o[i][c]); end
                end
            end
        end
        @(negedge clk);
        total++; if (bsy[2] !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", bsy[2]); end
    endtask

    task automatic test_overrun();
        pulse_reset();
        run_frame(12'h456, 12'hBCD, 1'b1, 5, 0, 12);
        model_step(12'h456, 12'hBCD);
        for (int i = 0; i < 3; i++) begin
            total++; if (vtr[i] !== 16'h1000 || ovr[i] !== 1'b1) begin bad++;
                $display("FAIL overrun_mac inst%0d: got v=%h o=%b want 1000/1", i, vtr[i], ovr[i]); end
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                    $display("FAIL overrun_out inst%0d ch%0d: got %h want %h", i, c, dout[i][c], exp_o[i][c]); end
            end
        end
        run_frame(12'h111, 12'hEEE, 1'b1, 0, 0, 12);
        model_step(12'h111, 12'hEEE);
        total++; if (ovr[2] !== 1'b1 || dout[2][0] !== exp_o[2][0]) begin bad++;
            $display("FAIL overrun_sticky: got o=%b d=%h want 1/%h", ovr[2], dout[2][0], exp_o[2][0]); end
        pulse_reset();
        total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", ovr[0]); end
        run_frame(12'h700, 12'h900, 1'b1, 12, 0, 13);
        model_step(12'h700, 12'h900);
        for (int i = 0; i < 3; i++) begin
            total++; if (vtr[i] !== 16'h1000 || btr[i] !== 16'h1ffe || ovr[i] !== 1'b1) begin bad++;
                $display("FAIL overrun_done inst%0d: got v=%h b=%h o=%b want 1000/1ffe/1", i, vtr[i], btr[i], ovr[i]); end
            total++; if (dout[i][0] !== exp_o[i][0]) begin bad++;
                $display("FAIL overrun_done_out inst%0d: got %h want %h", i, dout[i][0], exp_o[i][0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        pulse_reset();
        run_frame(12'h222, 12'hDDD, 1'b1, 0, 0, 3);
        run_frame(12'h345, 12'hCBA, 1'b1, 0, 0, 0);
        @(negedge clk);
        data_update_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({vld[i], bsy[i]} !== 2'b00 || dout[i][0] !== 12'h800 || dout[i][1] !== 12'h800) begin bad++;
                $display("FAIL reset_mid inst%0d: got v=%b b=%b d=%h/%h want 0/0/800/800", i, vld[i], bsy[i], dout[i][0], dout[i][1]); end
        end
        @(negedge clk);
        rst_i = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (vld[i]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_valid: got %b want 0", seen); end
        run_frame(12'h3C7, 12'hC38, 1'b1, 0, 0, 12);
        model_step(12'h3C7, 12'hC38);
        total++; if (dout[0][0] !== 12'h3C7 || dout[0][1] !== 12'hC38) begin bad++;
            $display("FAIL reset_mid_identity: got %h/%h want 3c7/c38", dout[0][0], dout[0][1]); end
        for (int i = 1; i < 3; i++)
            for (int c = 0; c < 2; c++) begin
                total++; if (dout[i][c] !== exp_o[i][c]) begin bad++;
                    $display("FAIL reset_mid_hist inst%0d ch%0d: got %h want %h", i, c, dout[i][c], exp_o[i][c]); end
            end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_en_low();
        test_en_fall();
        test_feedback();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
